tick_gen: RTL and testbench

Parametrised multi-channel enable-pulse generator, the successor to the fixed 1 Hz enable counter. Each of N_CH independent channels divides CLK by a runtime-programmable divisor and emits single-cycle enable pulses, either periodically or once per START (one-shot). After reset every channel runs periodically at DEFAULT_DIV, so the block drops in where a fixed divider was used. Downstream display, debounce and timer logic use EN[k] as a clock enable.

---
 rtl/tick_gen.sv | 80 ++++++++
 tb/tb_tick_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Multi-channel programmable enable-pulse generator.
// Each channel divides CLK by its own divisor and emits one-cycle EN pulses, periodically or once per START.
module tick_gen #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 2,
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [CH_W-1:0]  WADDR,
    input  logic [DIV_W-1:0] WDATA,
    input  logic             WMODE,
    input  logic [N_CH-1:0]  START,
    input  logic [N_CH-1:0]  STOP,
    output logic [N_CH-1:0]  EN,
    output logic [N_CH-1:0]  BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [N_CH-1:0] term;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic             mode_q;
        logic [DIV_W-1:0] cnt_q;
        state_t           state_q;
        logic [DIV_W-1:0] last_cnt;
        logic             wr_hit;

        // A divisor of 0 behaves like 1, so the last count is 0 in both cases.
        assign last_cnt = (div_q == '0) ? '0 : div_q - ONE;
        // NOTE: ">=" rather than "==" so a divisor shrunk below the running count fires at once instead of wrapping.
        assign term[k]  = (state_q == RUN) && (cnt_q >= last_cnt);
        assign EN[k]    = term[k] && !STOP[k];
        assign BUSY[k]  = (state_q == RUN);
        assign wr_hit   = WE && (WADDR == CH_W'(k));

        // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge CLK) begin
            if (RST) begin
                div_q   <= RESET_DIV;
                mode_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= RUN;
            end else begin
                if (wr_hit) begin
                    div_q  <= WDATA;
                    mode_q <= WMODE;
                end

                if (STOP[k]) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else if (START[k]) begin
                    cnt_q   <= '0;
                    state_q <= RUN;
                end else if (term[k]) begin
                    cnt_q <= '0;
                    if (mode_q) begin
                        state_q <= IDLE;
                    end
                end else if (state_q == RUN) begin
                    cnt_q <= cnt_q + ONE;
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: an anchor-based per-channel model checked every cycle,
// plus hand-computed pulse positions for reset, one-shot, shrink, collisions and edge divisors.
module tb_tick_gen;

    localparam int NCH = 3;
    localparam int CHW = 2;
    localparam int DW  = 8;
    localparam int DEF = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           we;
    logic [CHW-1:0] waddr;
    logic [DW-1:0]  wdata;
    logic           wmode;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] en;
    logic [NCH-1:0] busy;

    int n_vec = 0;
    int n_err = 0;

    tick_gen #(
        .N_CH(NCH),
        .CH_W(CHW),
        .DIV_W(DW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .WE(we),
        .WADDR(waddr),
        .WDATA(wdata),
        .WMODE(wmode),
        .START(start),
        .STOP(stop),
        .EN(en),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: each running channel remembers the cycle its current period began;
    // it fires once at least d_eff cycles of that period have elapsed.
    int             cyc = 0;
    bit             mvalid = 1'b0;
    int             mbase [NCH];
    bit             mrun  [NCH];
    int             mdiv  [NCH];
    bit             mmode [NCH];
    bit             mfire [NCH];
    logic [NCH-1:0] exp_en;
    logic [NCH-1:0] exp_busy;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < NCH; k++) begin
            int deff;
            deff        = (mdiv[k] == 0) ? 1 : mdiv[k];
            mfire[k]    = mrun[k] && ((cyc - mbase[k] + 1) >= deff);
            exp_en[k]   = mfire[k] && !stop[k];
            exp_busy[k] = mrun[k];
        end
        if (mvalid) begin
            check("model_en", en, exp_en);
            check("model_busy", busy, exp_busy);
        end
        for (int k = 0; k < NCH; k++) begin
            if (rst) begin
                mrun[k]  = 1'b1;
                mbase[k] = cyc + 1;
                mdiv[k]  = DEF;
                mmode[k] = 1'b0;
            end else begin
                if (stop[k]) begin
                    mrun[k] = 1'b0;
                end else if (start[k]) begin
                    mrun[k]  = 1'b1;
                    mbase[k] = cyc + 1;
                end else if (mfire[k]) begin
                    mbase[k] = cyc + 1;
                    if (mmode[k]) mrun[k] = 1'b0;
                end
                if (we && (int'(waddr) == k)) begin
                    mdiv[k]  = int'(wdata);
                    mmode[k] = wmode;
                end
            end
        end
        if (rst) mvalid = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic write(input int ch, input int d, input bit m);
        we    = 1'b1;
        waddr = CHW'(ch);
        wdata = DW'(d);
        wmode = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int second;
        int nfire;

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wmode = 1'b0;
        start = '0; stop = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset default: all channels fire in cycles 5, 10, 15.
        for (int j = 1; j <= 16; j++) begin
            at_neg();
            check("rst_en", en, (j % 5 == 0) ? 3'b111 : 3'b000);
            check("rst_busy", busy, 3'b111);
            tick();
        end

        // One-shot on channel 1 with D=4.
        write(1, 4, 1'b1);
        tick();
        we = 1'b0;
        start = 3'b010;
        tick();
        start = '0;
        for (int j = 1; j <= 20; j++) begin
            at_neg();
            check("oneshot_en", en[1], (j == 4));
            check("oneshot_busy", busy[1], (j <= 4));
            tick();
        end
        start = 3'b010;
        tick();
        start = '0;
        for (int j = 1; j <= 8; j++) begin
            at_neg();
            check("retrig_en", en[1], (j == 4));
            tick();
        end

        // Divisor shrink: channel 0 at D=10 rewritten to D=3 while cnt=6.
        write(0, 10, 1'b0);
        start = 3'b001;
        tick();
        we = 1'b0;
        start = '0;
        repeat (6) tick();
        write(0, 3, 1'b0);
        at_neg();
        check("shrink_pre", en[0], 1'b0);
        tick();
        we = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            at_neg();
            check("shrink_en", en[0], (j % 3 == 0));
            tick();
        end

        // STOP and START together: STOP wins.
        stop = 3'b001;
        start = 3'b001;
        at_neg();
        check("stopstart_en", en[0], 1'b0);
        tick();
        stop = '0;
        start = '0;
        for (int j = 1; j <= 5; j++) begin
            at_neg();
            check("stopped_en", en[0], 1'b0);
            check("stopped_busy", busy[0], 1'b0);
            tick();
        end

        // STOP in a terminal cycle suppresses EN.
        start = 3'b001;
        tick();
        start = '0;
        tick();
        tick();
        stop = 3'b001;
        at_neg();
        check("stop_term_en", en[0], 1'b0);
        tick();
        stop = '0;
        at_neg();
        check("stop_term_busy", busy[0], 1'b0);
        tick();

        // START in a terminal cycle still pulses and restarts.
        start = 3'b001;
        tick();
        start = '0;
        tick();
        tick();
        start = 3'b001;
        at_neg();
        check("start_term_en", en[0], 1'b1);
        tick();
        start = '0;
        for (int j = 1; j <= 3; j++) begin
            at_neg();
            check("start_term_next", en[0], (j == 3));
            tick();
        end

        // Edge divisors on channel 2: 0 and 1 fire every cycle.
        write(2, 0, 1'b0);
        tick();
        we = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            at_neg();
            check("div0_en", en[2], 1'b1);
            tick();
        end
        write(2, 1, 1'b0);
        tick();
        we = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            at_neg();
            check("div1_en", en[2], 1'b1);
            tick();
        end

        // Maximum divisor: period 255 without wrap.
        write(2, 255, 1'b0);
        start = 3'b100;
        tick();
        we = 1'b0;
        start = '0;
        first = 0;
        second = 0;
        nfire = 0;
        for (int j = 1; j <= 520; j++) begin
            at_neg();
            if (en[2]) begin
                nfire++;
                if (nfire == 1) first = j;
                if (nfire == 2) second = j;
            end
            tick();
        end
        check("max_first", first, 255);
        check("max_second", second, 510);
        check("max_count", nfire, 2);

        // Out-of-range writes are ignored; the model keeps checking for 100 cycles.
        for (int i = 0; i < 10; i++) begin
            write(3, i * 7 + 1, i[0]);
            tick();
        end
        we = 1'b0;
        repeat (100) tick();
        start = 3'b010;
        tick();
        start = '0;
        for (int j = 1; j <= 6; j++) begin
            at_neg();
            check("oor_oneshot", en[1], (j == 4));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
